// File: rtl/uart2wb_pkg.sv
// Shared constants for the UART-to-Wishbone debug bridge: bus widths, command
// and response bytes, and FSM state encodings.
package uart2wb_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'

  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?'

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_BUS  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

endpackage

// File: rtl/uart2wb_if.sv
// Byte-stream (UART PHY side) and Wishbone classic signals of the bridge.
// master = the bridge, slave = PHY/bus environment.
interface uart2wb_if
  import uart2wb_pkg::*;
#(
  parameter int unsigned addr_width = ADDR_WIDTH,
  parameter int unsigned data_width = DATA_WIDTH
) ();

  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [addr_width-1:0]   wb_adr;
  logic [data_width-1:0]   wb_datwr;
  logic [data_width-1:0]   wb_datrd;
  logic                    wb_we;
  logic [data_width/8-1:0] wb_sel;
  logic                    wb_stb;
  logic                    wb_cyc;
  logic                    wb_ack;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_datrd, wb_ack,
    output tx_data, tx_valid, wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wb_datrd, wb_ack,
    input  tx_data, tx_valid, wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc
  );

endinterface

// File: rtl/uart2wb_timer.sv
// Loadable saturating down-counter. expired goes high on the max_count-th
// cycle after the last load and stays high until the next load.
module uart2wb_timer #(
  parameter int unsigned max_count = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int unsigned W = $clog2(max_count + 1);

  logic [W-1:0] cnt_q;

  // Reload on request, otherwise count down and stick at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(max_count - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/uart2wb.sv
// UART-to-Wishbone bridge: decodes 'W'/'R' frames from the byte stream,
// runs one single Wishbone classic cycle per frame, and returns status or
// read data bytes to the host.
module uart2wb
  import uart2wb_pkg::*;
#(
  parameter int unsigned addr_width  = ADDR_WIDTH,
  parameter int unsigned data_width  = DATA_WIDTH,
  parameter int unsigned ack_timeout = 1024,
  parameter int unsigned rx_timeout  = 250000
) (
  input logic       clock,
  input logic       reset,
  uart2wb_if.master bus
);

  localparam int unsigned NA       = addr_width / 8;
  localparam int unsigned ND       = data_width / 8;
  localparam int unsigned MaxBytes = (NA > ND) ? NA : ND;
  localparam int unsigned CntW     = $clog2(MaxBytes + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t LastAddr = cnt_t'(NA - 1);
  localparam cnt_t LastData = cnt_t'(ND - 1);
  localparam cnt_t RespLen  = cnt_t'(ND);
  localparam cnt_t OneByte  = cnt_t'(1);

  logic [2:0]            state_q, state_d;
  logic                  is_write_q, is_write_d;
  cnt_t                  byte_cnt_q, byte_cnt_d;
  logic [addr_width-1:0] adr_q, adr_d;
  logic [data_width-1:0] dat_q, dat_d;
  logic [data_width-1:0] resp_q, resp_d;
  cnt_t                  resp_cnt_q, resp_cnt_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic                  tx_valid_q, tx_valid_d;

  logic rx_load, rx_expired;
  logic ack_load, ack_expired;

  // Inter-byte timer restarts on every byte; it is only consulted in ADDR/DATA.
  assign rx_load  = bus.rx_valid || (state_q == ST_IDLE);
  // Ack timer is held loaded outside BUS so it starts full on BUS entry.
  assign ack_load = (state_q != ST_BUS);

  uart2wb_timer #(.max_count(rx_timeout)) u_rx_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (rx_load),
    .expired (rx_expired)
  );

  uart2wb_timer #(.max_count(ack_timeout)) u_ack_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (ack_load),
    .expired (ack_expired)
  );

  // Frame decode, bus cycle control and response sequencing.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    byte_cnt_d = byte_cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
            is_write_d = (bus.rx_data == CMD_WRITE);
            byte_cnt_d = '0;
            state_d    = ST_ADDR;
          end else begin
            resp_d     = data_width'(RSP_BAD);
            resp_cnt_d = OneByte;
            tx_valid_d = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end

      ST_ADDR: begin
        // A byte arriving on the expiry cycle still counts.
        if (bus.rx_valid) begin
          adr_d      = (adr_q >> 8) | (addr_width'(bus.rx_data) << (addr_width - 8));
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LastAddr) begin
            byte_cnt_d = '0;
            if (is_write_q) begin
              state_d = ST_DATA;
            end else begin
              cyc_d   = 1'b1;
              state_d = ST_BUS;
            end
          end
        end else if (rx_expired) begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (bus.rx_valid) begin
          dat_d      = (dat_q >> 8) | (data_width'(bus.rx_data) << (data_width - 8));
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LastData) begin
            byte_cnt_d = '0;
            cyc_d      = 1'b1;
            we_d       = 1'b1;
            state_d    = ST_BUS;
          end
        end else if (rx_expired) begin
          state_d = ST_IDLE;
        end
      end

      ST_BUS: begin
        // Ack is checked first so a late ack on the expiry cycle succeeds.
        if (bus.wb_ack) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          tx_valid_d = 1'b1;
          state_d    = ST_RESP;
          if (is_write_q) begin
            resp_d     = data_width'(RSP_OK);
            resp_cnt_d = OneByte;
          end else begin
            resp_d     = bus.wb_datrd;
            resp_cnt_d = RespLen;
          end
        end else if (ack_expired) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          resp_d     = data_width'(RSP_ERR);
          resp_cnt_d = OneByte;
          tx_valid_d = 1'b1;
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        if (bus.tx_ready) begin
          resp_d     = resp_q >> 8;
          resp_cnt_d = resp_cnt_q - 1'b1;
          if (resp_cnt_q == OneByte) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end

      default: begin
        cyc_d      = 1'b0;
        we_d       = 1'b0;
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the bus cycle immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_write_q <= 1'b0;
      byte_cnt_q <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      byte_cnt_q <= byte_cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign bus.tx_data  = resp_q[7:0];
  assign bus.tx_valid = tx_valid_q;
  assign bus.wb_adr   = adr_q;
  assign bus.wb_datwr = dat_q;
  assign bus.wb_we    = we_q;
  assign bus.wb_sel   = {(data_width / 8){cyc_q}};
  assign bus.wb_stb   = cyc_q;
  assign bus.wb_cyc   = cyc_q;

endmodule

// File: tb/tb_uart2wb.sv
// Directed self-checking bench for uart2wb with a short ack/rx timeout.
module tb_uart2wb;

  localparam int unsigned AckTo = 16;
  localparam int unsigned RxTo  = 40;

  logic clock;
  logic reset;

  uart2wb_if #(.addr_width(32), .data_width(32)) bus_if ();

  uart2wb #(
    .addr_width  (32),
    .data_width  (32),
    .ack_timeout (AckTo),
    .rx_timeout  (RxTo)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Responder / collector configuration and observations.
  int          ack_delay;
  logic [31:0] rd_data;
  int          stb_cnt, last_cyc_len, bus_cycles, stb_err;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;
  logic [7:0]  tx_q[$];
  int          stall_idx, stall_len, stall_seen, hold_err;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    tx_q.delete();
    bus_cycles = 0;
    stall_seen = 0;
    hold_err   = 0;
    stb_err    = 0;
    stall_idx  = -1;
    stall_len  = 0;
    cap_adr    = 'x;
    cap_dat    = 'x;
    cap_we     = 1'bx;
    cap_sel    = 'x;
  endtask

  // Wishbone slave: acks ack_delay cycles after stb is first seen (-1 = never).
  task automatic responder_loop();
    forever begin
      tick();
      if (reset) begin
        bus_if.wb_ack = 1'b0;
        stb_cnt = 0;
        continue;
      end
      if (bus_if.wb_stb !== bus_if.wb_cyc) stb_err++;
      if (bus_if.wb_cyc === 1'b1) begin
        stb_cnt++;
        if (stb_cnt == 1) begin
          cap_adr = bus_if.wb_adr;
          cap_dat = bus_if.wb_datwr;
          cap_we  = bus_if.wb_we;
          cap_sel = bus_if.wb_sel;
        end
        if (ack_delay >= 0 && stb_cnt == ack_delay + 1) begin
          bus_if.wb_ack   = 1'b1;
          bus_if.wb_datrd = rd_data;
        end else begin
          bus_if.wb_ack   = 1'b0;
          bus_if.wb_datrd = '0;
        end
      end else begin
        if (stb_cnt != 0) begin
          last_cyc_len = stb_cnt;
          bus_cycles++;
        end
        stb_cnt = 0;
        bus_if.wb_ack = 1'b0;
      end
    end
  endtask

  // Transmitter: accepts bytes, optionally stalling byte stall_idx.
  task automatic collector_loop();
    logic [7:0] held;
    int stalled;
    stalled = 0;
    held = '0;
    forever begin
      tick();
      if (reset) begin
        bus_if.tx_ready = 1'b0;
        stalled = 0;
        continue;
      end
      if (bus_if.tx_valid === 1'b1) begin
        if (stalled == 0) held = bus_if.tx_data;
        else if (bus_if.tx_data !== held) hold_err++;
        if (tx_q.size() == stall_idx && stalled < stall_len) begin
          bus_if.tx_ready = 1'b0;
          stalled++;
          stall_seen++;
        end else begin
          bus_if.tx_ready = 1'b1;
          tx_q.push_back(bus_if.tx_data);
          stalled = 0;
        end
      end else begin
        bus_if.tx_ready = 1'b0;
        stalled = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    tick();
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_tx(input int n, input string name);
    int k;
    k = 0;
    while (tx_q.size() < n && k < 400) begin
      tick();
      k++;
    end
    repeat (4) tick();
    n_cmp++;
    if (tx_q.size() != n) begin
      n_fail++;
      $display("FAIL %s tx_count: got %0d want %0d", name, tx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    n_cmp++;
    if ({bus_if.wb_cyc, bus_if.wb_stb, bus_if.wb_we, bus_if.tx_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0000",
               {bus_if.wb_cyc, bus_if.wb_stb, bus_if.wb_we, bus_if.tx_valid});
    end
    n_cmp++;
    if ({bus_if.wb_adr, bus_if.wb_datwr} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_adr_dat: got %h want 0", {bus_if.wb_adr, bus_if.wb_datwr});
    end
    n_cmp++;
    if ({bus_if.wb_sel, bus_if.tx_data} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_sel_txd: got %h want 0", {bus_if.wb_sel, bus_if.tx_data});
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    clear_obs();
    ack_delay = 2;
    send_byte(8'h57);
    send_word(32'h8000_0010);
    send_word(32'hDEAD_BEEF);
    n_cmp++;
    if (bus_if.wb_cyc !== 1'b1) begin
      n_fail++;
      $display("FAIL write_cyc_start: got %b want 1", bus_if.wb_cyc);
    end
    wait_tx(1, "write");
    n_cmp++;
    if (cap_adr !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL write_adr: got %h want 80000010", cap_adr);
    end
    n_cmp++;
    if (cap_dat !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_dat: got %h want deadbeef", cap_dat);
    end
    n_cmp++;
    if ({cap_we, cap_sel} !== 5'b1_1111) begin
      n_fail++;
      $display("FAIL write_we_sel: got %b want 11111", {cap_we, cap_sel});
    end
    n_cmp++;
    if (last_cyc_len != 3 || bus_cycles != 1 || stb_err != 0) begin
      n_fail++;
      $display("FAIL write_cyc_len: got len=%0d n=%0d stberr=%0d want 3 1 0",
               last_cyc_len, bus_cycles, stb_err);
    end
    n_cmp++;
    if (tx_q.size() < 1 || tx_q[0] !== 8'h4B) begin
      n_fail++;
      $display("FAIL write_resp: got %h want 4b", (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_read();
    clear_obs();
    ack_delay = 1;
    rd_data   = 32'h1234_5678;
    stall_idx = 1;
    stall_len = 5;
    send_byte(8'h52);
    send_word(32'h8000_0004);
    wait_tx(4, "read");
    n_cmp++;
    if (cap_adr !== 32'h8000_0004 || cap_we !== 1'b0 || cap_sel !== 4'hF) begin
      n_fail++;
      $display("FAIL read_bus: got adr=%h we=%b sel=%h want 80000004 0 f",
               cap_adr, cap_we, cap_sel);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= tx_q.size() || tx_q[i] !== rd_data[8*i +: 8]) begin
        n_fail++;
        $display("FAIL read_byte%0d: got %h want %h", i,
                 (i < tx_q.size()) ? tx_q[i] : 8'hxx, rd_data[8*i +: 8]);
      end
    end
    n_cmp++;
    if (stall_seen != 5 || hold_err != 0) begin
      n_fail++;
      $display("FAIL read_stall_hold: got stall=%0d holderr=%0d want 5 0",
               stall_seen, hold_err);
    end
  endtask

  task automatic test_ack_timeout();
    clear_obs();
    ack_delay = -1;
    send_byte(8'h57);
    send_word(32'h0000_0020);
    send_word(32'h4433_2211);
    wait_tx(1, "ack_to");
    n_cmp++;
    if (last_cyc_len != int'(AckTo) || bus_cycles != 1) begin
      n_fail++;
      $display("FAIL ack_to_len: got len=%0d n=%0d want %0d 1", last_cyc_len, bus_cycles, AckTo);
    end
    n_cmp++;
    if (tx_q.size() < 1 || tx_q[0] !== 8'h45) begin
      n_fail++;
      $display("FAIL ack_to_resp: got %h want 45", (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
    // Recovery: next read completes.
    clear_obs();
    ack_delay = 0;
    rd_data   = 32'hCAFE_F00D;
    send_byte(8'h52);
    send_word(32'h0000_0008);
    wait_tx(4, "ack_to_next");
    n_cmp++;
    if (tx_q.size() != 4 || {tx_q[3], tx_q[2], tx_q[1], tx_q[0]} !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL ack_to_next_data: got %0d bytes want cafef00d", tx_q.size());
    end
  endtask

  task automatic test_bad_and_rx_timeout();
    clear_obs();
    send_byte(8'h41);
    wait_tx(1, "bad_op");
    n_cmp++;
    if (tx_q.size() < 1 || tx_q[0] !== 8'h3F || bus_cycles != 0) begin
      n_fail++;
      $display("FAIL bad_op_resp: got %h cycles=%0d want 3f 0",
               (tx_q.size() > 0) ? tx_q[0] : 8'hxx, bus_cycles);
    end
    clear_obs();
    send_byte(8'h52);
    send_byte(8'h04);
    repeat (RxTo + 20) tick();
    n_cmp++;
    if (bus_cycles != 0 || tx_q.size() != 0 || bus_if.wb_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_to_silent: got cycles=%0d tx=%0d want 0 0", bus_cycles, tx_q.size());
    end
    // Full read with each byte arriving exactly on the expiry cycle.
    clear_obs();
    ack_delay = 0;
    rd_data   = 32'hA5A5_5A5A;
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) begin
      repeat (RxTo - 1) tick();
      send_byte(8'(32'h0000_0100 >> (8 * i)));
    end
    wait_tx(4, "rx_edge");
    n_cmp++;
    if (cap_adr !== 32'h0000_0100 || bus_cycles != 1) begin
      n_fail++;
      $display("FAIL rx_edge_bus: got adr=%h cycles=%0d want 00000100 1", cap_adr, bus_cycles);
    end
    n_cmp++;
    if (tx_q.size() != 4 || {tx_q[3], tx_q[2], tx_q[1], tx_q[0]} !== 32'hA5A5_5A5A) begin
      n_fail++;
      $display("FAIL rx_edge_data: got %0d bytes want a5a55a5a", tx_q.size());
    end
  endtask

  task automatic test_reset_mid_bus();
    clear_obs();
    ack_delay = -1;
    send_byte(8'h57);
    send_word(32'h0000_0030);
    send_word(32'h55AA_55AA);
    repeat (3) tick();
    n_cmp++;
    if (bus_if.wb_cyc !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_bus_pre: got cyc=%b want 1", bus_if.wb_cyc);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus_if.wb_cyc, bus_if.wb_stb, bus_if.tx_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_bus_async: got %b want 000",
               {bus_if.wb_cyc, bus_if.wb_stb, bus_if.tx_valid});
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();
    repeat (30) tick();
    n_cmp++;
    if (tx_q.size() != 0 || bus_cycles != 0 || bus_if.wb_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_bus_after: got tx=%0d cycles=%0d cyc=%b want 0 0 0",
               tx_q.size(), bus_cycles, bus_if.wb_cyc);
    end
  endtask

  task automatic test_extra_bytes();
    clear_obs();
    ack_delay = 3;
    rd_data   = 32'h0BAD_F00D;
    stall_idx = 0;
    stall_len = 6;
    send_byte(8'h52);
    send_word(32'h0000_000C);
    // Injected while the bus cycle and the response are in progress.
    send_byte(8'h57);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'h41);
    wait_tx(4, "extra");
    n_cmp++;
    if (tx_q.size() != 4 || {tx_q[3], tx_q[2], tx_q[1], tx_q[0]} !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL extra_data: got %0d bytes want 0badf00d", tx_q.size());
    end
    n_cmp++;
    if (bus_cycles != 1 || cap_adr !== 32'h0000_000C) begin
      n_fail++;
      $display("FAIL extra_bus: got cycles=%0d adr=%h want 1 0000000c", bus_cycles, cap_adr);
    end
    clear_obs();
    ack_delay = 0;
    send_byte(8'h57);
    send_word(32'h0000_0044);
    send_word(32'h0102_0304);
    wait_tx(1, "extra_next");
    n_cmp++;
    if (tx_q.size() < 1 || tx_q[0] !== 8'h4B || cap_adr !== 32'h0000_0044 ||
        cap_dat !== 32'h0102_0304) begin
      n_fail++;
      $display("FAIL extra_next: got resp=%h adr=%h dat=%h want 4b 00000044 01020304",
               (tx_q.size() > 0) ? tx_q[0] : 8'hxx, cap_adr, cap_dat);
    end
  endtask

  initial begin
    bus_if.rx_data  = '0;
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b0;
    bus_if.wb_datrd = '0;
    bus_if.wb_ack   = 1'b0;
    ack_delay    = -1;
    rd_data      = '0;
    stb_cnt      = 0;
    last_cyc_len = 0;
    clear_obs();
    fork
      responder_loop();
      collector_loop();
    join_none
    test_reset();
    test_write();
    test_read();
    test_ack_timeout();
    test_bad_and_rx_timeout();
    test_reset_mid_bus();
    test_extra_bytes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart2wb.md
Name: uart2wb

Overview:
- Debug/loader bridge: a Wishbone classic initiator driven by a host over a byte stream (the received-byte and transmit-byte sides of a UART PHY).
- Decodes simple read/write command frames, issues one single Wishbone cycle per frame, and returns status/data bytes to the host.
- Sits beside the CPU as a second bus master, behind an external arbiter, so memory and peripherals can be loaded and inspected over UART.

Parameters:
- addr_width, 32, Wishbone address width; multiple of 8; sets the number of address bytes NA = addr_width/8.
- data_width, 32, Wishbone data width; multiple of 8; sets the number of data bytes ND = data_width/8; sel width = data_width/8.
- ack_timeout, 1024, max cycles cyc/stb stay asserted awaiting wb_ack before the cycle is abandoned.
- rx_timeout, 250000, max idle cycles between bytes of one frame (10 ms at 25 MHz) before the frame is discarded.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held with tx_data stable until tx_ready.
- tx_ready  in  1  transmitter accepts the byte in a cycle with tx_valid=1.
- wb_adr  out  addr_width  bus address.
- wb_datwr  out  data_width  write data.
- wb_datrd  in  data_width  read data, sampled when wb_ack=1.
- wb_we  out  1  1 = write cycle.
- wb_sel  out  data_width/8  byte selects.
- wb_stb  out  1  strobe.
- wb_cyc  out  1  cycle valid.
- wb_ack  in  1  responder acknowledge.

Behaviour:
- Reset: all outputs 0 (wb_cyc, wb_stb, wb_we, wb_adr, wb_datwr, wb_sel, tx_valid, tx_data); FSM to IDLE; counters cleared. Reset mid-cycle drops cyc/stb immediately with no response byte.
- Frame formats, multi-byte fields LSB first:
  - Write: 0x57 'W', NA address bytes, ND data bytes. Response 0x4B 'K' on ack, 0x45 'E' on timeout.
  - Read: 0x52 'R', NA address bytes. Response is ND data bytes on ack, 0x45 on timeout.
  - Any other first byte: respond 0x3F '?'.
- FSM states IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: on rx_valid, decode the byte. W/R go to ADDR with byte_cnt=0 and the opcode latched; other bytes load 0x3F and go to RESP.
  - ADDR: each rx_valid shifts a byte into the address register. After byte NA: W goes to DATA, R goes to BUS.
  - DATA: each rx_valid shifts a byte into the write-data register. After byte ND, go to BUS.
  - BUS: cyc=stb=1 from the cycle after the last frame byte is registered. we=1 for write; sel all ones; adr/datwr from the registers.
    - wb_ack=1: drop cyc/stb/we next cycle, capture wb_datrd for reads, go to RESP.
    - ack_timeout cycles without ack: drop cyc/stb, load 0x45, go to RESP.
    - Ack arriving in the same cycle as the timeout expiry counts as success.
  - RESP: tx_valid=1 the cycle after entry. Each tx_ready handshake advances to the next byte. After the last handshake, tx_valid=0 and go to IDLE.
- rx_valid while in BUS or RESP: byte dropped, no state effect.
- Inter-byte timeout: in ADDR/DATA, counter reset on every rx_valid. Reaching rx_timeout returns to IDLE silently with no bus cycle. If rx_valid and expiry coincide, the byte wins.
- Only single cycles: no bursts, no pipelined mode, cyc never held across frames. Address passed verbatim; no alignment check.
- Timeout counters sized $clog2(param+1) and saturate; no wrap.

Decomposition:
- Shared package/header (with the existing bus-width defines):
  - opcode constants CMD_WRITE=8'h57, CMD_READ=8'h52;
  - response constants RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_BAD=8'h3F;
  - FSM state encodings.
- One natural sub-module, uart2wb_timer: loadable saturating down-counter with an expired flag, instantiated twice (rx timeout, ack timeout).
- A top-level wrapper pairs the block with the existing UART PHY and a bus arbiter.

Test Plan:
- Write 57 10 00 00 80 EF BE AD DE, ack 2 cycles after stb -> one cycle adr=0x80000010, datwr=0xDEADBEEF, we=1, sel=0xF; cyc drops the cycle after ack; tx 0x4B.
- Read 52 04 00 00 80, ack with datrd=0x12345678 -> we=0 cycle at 0x80000004; tx 78 56 34 12 in order, each held until tx_ready, including tx_ready stalled 5 cycles on byte 2.
- Never ack (ack_timeout=16) -> cyc/stb high exactly 16 cycles then low; tx 0x45; next valid frame completes normally.
- Bad opcode 0x41 -> tx 0x3F, no bus cycle. Then 52 04 followed by silence past rx_timeout -> no bus cycle, no tx; following full read succeeds.
- Assert reset during BUS with cyc=1 -> cyc, stb, tx_valid 0 immediately (asynchronously); after release, idle with no stray response.
- Extra rx_valid bytes injected during BUS and RESP -> ignored; frame result unchanged; next frame decoded from a clean IDLE.
